dcro_tuner: RTL and testbench

- Closed-loop frequency tuner for the digitally controlled ring oscillator: measures oscillator edges over a fixed reference-clock window and successive-approximation searches the oscillator tap select until the count matches a target.
- Sits between system control logic (start/target/status) and one oscillator instance (enable, sel, out).
- After lock it holds sel and enable so the oscillator keeps running at the tuned frequency.

---
 rtl/dcro_pkg.sv | 31 +++
 rtl/dcro_edge_counter.sv | 49 ++++
 rtl/dcro_tuner.sv | 154 +++++++++++++++
 tb/tb_dcro_tuner.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcro_pkg.sv
// Shared definitions for the ring-oscillator tuner: default widths, FSM state
// encoding and the Gray-to-binary helper used by the edge counter.
`timescale 1ps/1ps
package dcro_pkg;

  localparam int DEF_SEL_LEN = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int GRAY_MAX_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SETTLE,
    ST_WSTART,
    ST_WINDOW,
    ST_WEND,
    ST_EVAL,
    ST_CHECK
  } tune_state_t;

  // Narrower codes are zero-extended by the caller; leading zeros convert to zeros.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/dcro_edge_counter.sv
// Counts oscillator rising edges in a Gray-coded register and re-times the code
// into the reference clock domain, presenting a binary count there.
`timescale 1ps/1ps
module dcro_edge_counter
  import dcro_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             rst,
  input  logic             osc_in,
  input  logic             clk,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] osc_bin;
  logic [CNT_W-1:0] osc_next;
  logic [CNT_W-1:0] osc_gray;
  logic [CNT_W-1:0] sync1;
  logic [CNT_W-1:0] sync2;

  assign osc_next = osc_bin + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge osc_in or negedge rst) begin
    if (!rst) begin
      osc_bin  <= '0;
      osc_gray <= '0;
    end else begin
      osc_bin  <= osc_next;
      osc_gray <= osc_next ^ (osc_next >> 1);
    end
  end

  // Only one Gray bit changes per oscillator edge, so a late sample is off by
  // at most one count rather than a corrupted multi-bit value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      count <= '0;
    end else begin
      sync1 <= osc_gray;
      sync2 <= sync1;
      count <= CNT_W'(gray2bin(GRAY_MAX_W'(sync2)));
    end
  end

endmodule

// File: rtl/dcro_tuner.sv
// Closed-loop tuner: successive-approximation search of the ring oscillator
// tap select against an edge count measured over a fixed reference window.
`timescale 1ps/1ps
module dcro_tuner
  import dcro_pkg::*;
#(
  parameter int SEL_LEN       = DEF_SEL_LEN,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WIN_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   target,
  input  logic [CNT_W-1:0]   tol,
  input  logic               dcro_out,
  output logic               dcro_enable,
  output logic [SEL_LEN-1:0] dcro_sel,
  output logic               busy,
  output logic               locked,
  output logic               fail,
  output logic [CNT_W-1:0]   meas_count
);

  localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int K_W     = (SEL_LEN > 1) ? $clog2(SEL_LEN) : 1;

  tune_state_t      state;
  logic [TMR_W-1:0] tmr;
  logic [K_W-1:0]   k;
  logic             final_pass;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] tol_r;
  logic [CNT_W-1:0] start_sample;
  logic [CNT_W-1:0] end_sample;
  logic [CNT_W-1:0] sync_count;
  logic [CNT_W-1:0] err;

  dcro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .rst    (rst),
    .osc_in (dcro_out),
    .clk    (clk),
    .count  (sync_count)
  );

  assign err = (meas_count >= tgt) ? (meas_count - tgt) : (tgt - meas_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      k            <= '0;
      final_pass   <= 1'b0;
      tgt          <= '0;
      tol_r        <= '0;
      start_sample <= '0;
      end_sample   <= '0;
      dcro_enable  <= 1'b0;
      dcro_sel     <= '0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      meas_count   <= '0;
    end else if (abort && busy) begin
      // Cancel keeps the partial select so software can inspect where the search stopped.
      state       <= ST_IDLE;
      tmr         <= '0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b1;
      dcro_enable <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            tgt         <= target;
            tol_r       <= tol;
            locked      <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b1;
            dcro_enable <= 1'b1;
            k           <= K_W'(SEL_LEN - 1);
            dcro_sel    <= SEL_LEN'(1) << (SEL_LEN - 1);
            final_pass  <= 1'b0;
            tmr         <= '0;
            state       <= ST_START;
          end
        end
        ST_START: state <= ST_SETTLE;
        ST_SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
            tmr   <= '0;
            state <= ST_WSTART;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WSTART: begin
          start_sample <= sync_count;
          state        <= ST_WINDOW;
        end
        ST_WINDOW: begin
          // End sample is taken exactly WIN_CYCLES edges after the start sample.
          if (tmr == TMR_W'(WIN_CYCLES - 1)) begin
            tmr        <= '0;
            end_sample <= sync_count;
            state      <= ST_WEND;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WEND: begin
          // Modular difference absorbs counter wrap inside the window.
          meas_count <= end_sample - start_sample;
          state      <= ST_EVAL;
        end
        ST_EVAL: begin
          if (final_pass) begin
            state <= ST_CHECK;
          end else begin
            // Too many edges means too fast: keep the bit to lengthen the loop.
            if (!(meas_count > tgt)) begin
              dcro_sel[k] <= 1'b0;
            end
            if (k != '0) begin
              dcro_sel[k - 1'b1] <= 1'b1;
              k                  <= k - 1'b1;
            end else begin
              final_pass <= 1'b1;
            end
            state <= ST_SETTLE;
          end
        end
        ST_CHECK: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (err <= tol_r) begin
            locked <= 1'b1;
          end else begin
            fail        <= 1'b1;
            dcro_enable <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcro_tuner.sv
// Self-checking bench for dcro_tuner with a behavioural ring oscillator whose
// period is (sel+1) ns, plus an 8-bit-counter instance driven at a fixed 7 ns.
`timescale 1ps/1ps
module tb_dcro_tuner;

  localparam int LATENCY   = 9 * (16 + 1000 + 3) + 2;
  localparam int MAX_WAIT  = 12000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] target;
  logic [15:0] tol;
  logic        dcro_out;
  logic        dcro_enable;
  logic [7:0]  dcro_sel;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [15:0] meas_count;

  logic        start_w;
  logic        osc_w;
  logic        en_w;
  logic [7:0]  sel_w;
  logic        busy_w;
  logic        locked_w;
  logic        fail_w;
  logic [7:0]  meas_w;

  int total = 0;
  int bad   = 0;
  int half_ps;

  dcro_tuner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .tol         (tol),
    .dcro_out    (dcro_out),
    .dcro_enable (dcro_enable),
    .dcro_sel    (dcro_sel),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .meas_count  (meas_count)
  );

  dcro_tuner #(
    .SEL_LEN       (8),
    .CNT_W         (8),
    .WIN_CYCLES    (1000),
    .SETTLE_CYCLES (16)
  ) dut_w (
    .clk         (clk),
    .rst         (rst),
    .start       (start_w),
    .abort       (1'b0),
    .target      (8'd0),
    .tol         (8'd0),
    .dcro_out    (osc_w),
    .dcro_enable (en_w),
    .dcro_sel    (sel_w),
    .busy        (busy_w),
    .locked      (locked_w),
    .fail        (fail_w),
    .meas_count  (meas_w)
  );

  initial clk = 1'b0;
  always #5000 clk = ~clk;

  always begin
    if (dcro_enable) begin
      half_ps  = (int'(dcro_sel) + 1) * 500;
      dcro_out = 1'b1;
      #(half_ps);
      dcro_out = 1'b0;
      #(half_ps);
    end else begin
      dcro_out = 1'b0;
      #1000;
    end
  end

  always begin
    if (en_w) begin
      osc_w = 1'b1;
      #3500;
      osc_w = 1'b0;
      #3500;
    end else begin
      osc_w = 1'b0;
      #1000;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Ideal edges per 10 us window for a (s+1) ns oscillator period.
  function automatic real ideal(input int s);
    return 10000.0 / real'(s + 1);
  endfunction

  // Successive approximation over the ideal count curve.
  function automatic int model_sar(input int tgt_v);
    int s = 0;
    for (int b = 7; b >= 0; b--) begin
      s = s | (1 << b);
      if (!(ideal(s) > real'(tgt_v))) s = s & ~(1 << b);
    end
    return s;
  endfunction

  // Pulses start, then counts busy cycles; a foreign start is injected mid-tune.
  task automatic run_tune(input int tgt_v, input int tol_v, output int cycles);
    start  = 1'b1;
    target = 16'(tgt_v);
    tol    = 16'(tol_v);
    @(negedge clk);
    start   = 1'b0;
    start_w = 1'b0;
    cycles  = 0;
    while (busy && cycles < MAX_WAIT) begin
      cycles++;
      if (cycles == 500) begin
        start  = 1'b1;
        target = 16'd20000;
      end else if (cycles == 501) begin
        start  = 1'b0;
        target = 16'(tgt_v);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int target;
    int tol;
    int sel_lo;
    int sel_hi;
    int cnt_lo;
    int cnt_hi;
    bit exp_locked;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;
    int sel_before;
    int ms;
    int lo_s;
    int hi_s;
    int tgt_v;
    int tol_v;
    real worst;

    vecs[0] = '{target: 100,   tol: 2,   sel_lo: 98,  sel_hi: 100, cnt_lo: 98,   cnt_hi: 102,   exp_locked: 1'b1};
    vecs[1] = '{target: 20000, tol: 10,  sel_lo: 0,   sel_hi: 0,   cnt_lo: 9999, cnt_hi: 10001, exp_locked: 1'b0};
    vecs[2] = '{target: 2000,  tol: 600, sel_lo: 3,   sel_hi: 5,   cnt_lo: 1600, cnt_hi: 2600,  exp_locked: 1'b1};
    vecs[3] = '{target: 0,     tol: 5,   sel_lo: 255, sel_hi: 255, cnt_lo: 39,   cnt_hi: 40,    exp_locked: 1'b0};

    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    target  = '0;
    tol     = '0;
    start_w = 1'b0;

    repeat (3) @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst enable", int'(dcro_enable), 0);
    check("rst sel", int'(dcro_sel), 0);
    check("rst meas", int'(meas_count), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle busy", int'(busy), 0);
    check("idle locked", int'(locked), 0);
    check("idle fail", int'(fail), 0);
    check("idle enable", int'(dcro_enable), 0);

    // Reset asserted mid-tune, away from any clock edge.
    start  = 1'b1;
    target = 16'd100;
    tol    = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre-reset busy", int'(busy), 1);
    #2000;
    rst = 1'b0;
    #1000;
    check("midreset busy", int'(busy), 0);
    check("midreset enable", int'(dcro_enable), 0);
    check("midreset sel", int'(dcro_sel), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Abort 3000 cycles into a tune.
    start  = 1'b1;
    target = 16'd100;
    tol    = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2999) @(negedge clk);
    sel_before = int'(dcro_sel);
    abort      = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort fail", int'(fail), 1);
    check("abort locked", int'(locked), 0);
    check("abort enable", int'(dcro_enable), 0);
    check("abort sel held", int'(dcro_sel), sel_before);

    // Start and abort together while idle: nothing happens.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", int'(busy), 0);
    check("start+abort fail", int'(fail), 1);
    repeat (3) @(negedge clk);
    check("start+abort busy later", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      start_w = (i == 0);
      run_tune(vecs[i].target, vecs[i].tol, cyc);
      check($sformatf("v%0d latency", i), cyc, LATENCY);
      check($sformatf("v%0d busy", i), int'(busy), 0);
      check_range($sformatf("v%0d sel", i), int'(dcro_sel), vecs[i].sel_lo, vecs[i].sel_hi);
      check_range($sformatf("v%0d meas", i), int'(meas_count), vecs[i].cnt_lo, vecs[i].cnt_hi);
      check($sformatf("v%0d locked", i), int'(locked), int'(vecs[i].exp_locked));
      check($sformatf("v%0d fail", i), int'(fail), int'(!vecs[i].exp_locked));
      check($sformatf("v%0d enable", i), int'(dcro_enable), int'(vecs[i].exp_locked));
      if (i == 0) begin
        // 7 ns over 10 us is 1428 or 1429 edges; the 8-bit count keeps it mod 256.
        cyc = 0;
        while (busy_w && cyc < 100) begin
          cyc++;
          @(negedge clk);
        end
        check("wrap busy", int'(busy_w), 0);
        check_range("wrap meas", int'(meas_w), 1428 % 256, 1429 % 256);
        check("wrap sel", int'(sel_w), 255);
        check("wrap fail", int'(fail_w), 1);
        check("wrap locked", int'(locked_w), 0);
      end
    end

    // Random targets against the ideal-curve SAR model, tolerance wide enough to lock.
    for (int r = 0; r < 2; r++) begin
      tgt_v = int'($urandom_range(5000, 170));
      ms    = model_sar(tgt_v);
      lo_s  = (ms > 0) ? ms - 1 : 0;
      hi_s  = (ms < 255) ? ms + 1 : 255;
      worst = 0.0;
      for (int s = lo_s; s <= hi_s; s++) begin
        if (ideal(s) - real'(tgt_v) > worst) worst = ideal(s) - real'(tgt_v);
        if (real'(tgt_v) - ideal(s) > worst) worst = real'(tgt_v) - ideal(s);
      end
      tol_v = int'($ceil(worst)) + 3;
      run_tune(tgt_v, tol_v, cyc);
      check($sformatf("rnd%0d latency", r), cyc, LATENCY);
      check_range($sformatf("rnd%0d sel t=%0d", r, tgt_v), int'(dcro_sel), lo_s, hi_s);
      check_range($sformatf("rnd%0d meas", r), int'(meas_count),
                  int'($floor(ideal(hi_s))) - 1, int'($ceil(ideal(lo_s))) + 1);
      check($sformatf("rnd%0d locked", r), int'(locked), 1);
      check($sformatf("rnd%0d fail", r), int'(fail), 0);
      check($sformatf("rnd%0d enable", r), int'(dcro_enable), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
